uart_rx_multi: RTL and testbench

UART_RX_MULTI -- requirements
Module: uart_rx_multi

---
 rtl/uart_pkg.sv | 35 +++
 rtl/uart_baud_gen.sv | 39 +++
 rtl/uart_rx_multi.sv | 209 ++++++++++++++++++++
 tb/tb_uart_rx_multi.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared types and helpers for the UART receiver.
// Holds the receiver FSM state encoding, the PARITY parameter encoding
// and small bit-level helper functions (majority vote, parity).
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_START   = 3'd1,
        ST_DATA    = 3'd2,
        ST_PARITY  = 3'd3,
        ST_STOP    = 3'd4,
        ST_RECOVER = 3'd5
    } state_t;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    // 2-of-3 majority vote of three line samples
    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    // Parity bit the transmitter is expected to send for the given data
    function automatic logic parity_bit(input logic [7:0] data, input int mode);
        logic p;
        if (mode == PAR_ODD) begin
            p = ~(^data);
        end else begin
            p = ^data;
        end
        return p;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: per-bit baud counter for the UART receiver.
// Counts 0..BAUD_CNT_MAX-1 and wraps; restart forces the count back to 0.
// smp_stb marks the bit-value decision cycle (count BAUD_CNT_MAX/2+1), one
// cycle after the nominal sample point so that the three samples around
// the centre are available for a majority vote; bit_end marks the last count.
module uart_baud_gen #(
    parameter int BAUD_CNT_MAX = 2604
) (
    input  logic clk,
    input  logic rst_n,
    input  logic restart,
    output logic smp_stb,
    output logic bit_end
);

    localparam int CW = $clog2(BAUD_CNT_MAX + 1);
    localparam logic [CW-1:0] CNT_LAST   = CW'(BAUD_CNT_MAX - 1);
    localparam logic [CW-1:0] CNT_DECIDE = CW'(BAUD_CNT_MAX / 2 + 1);
    localparam logic [CW-1:0] CNT_ONE    = CW'(1);

    logic [CW-1:0] cnt_r;

    // Baud counter: restart on state entry, otherwise wrap at the bit end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= '0;
        end else if (restart) begin
            cnt_r <= '0;
        end else if (cnt_r == CNT_LAST) begin
            cnt_r <= '0;
        end else begin
            cnt_r <= cnt_r + CNT_ONE;
        end
    end

    assign smp_stb = (cnt_r == CNT_DECIDE);
    assign bit_end = (cnt_r == CNT_LAST);

endmodule

// File: rtl/uart_rx_multi.sv
// uart_rx_multi: configurable UART receiver (5..8 data bits, none/odd/even
// parity, 1 or 2 stop bits) with break recovery.
// Build option: define UART_RX_MAJORITY_EN to decide each bit by a 2-of-3
// majority of the samples at counts BAUD_CNT_MAX/2-1, /2 and /2+1; without
// it the single sample at BAUD_CNT_MAX/2 is used. Timing is the same in both.
module uart_rx_multi #(
    parameter int CLK_FREQ  = 25_000_000,
    parameter int BAUD_RATE = 9600,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       rx,
    output logic [7:0] po_data,
    output logic       po_flag,
    output logic       parity_err,
    output logic       frame_err
);

    import uart_pkg::*;

    localparam int BAUD_CNT_MAX = CLK_FREQ / BAUD_RATE;
    localparam logic [3:0] DATA_CNT  = 4'(DATA_BITS);
    localparam logic       LAST_STOP = 1'(STOP_BITS - 1);

    state_t     state;
    state_t     state_next;
    logic       rx_s1;
    logic       rx_s2;
    logic       rx_d;
    logic       fall;
    logic       bit_val;
    logic       smp_stb;
    logic       bit_end;
    logic       restart;
    logic [7:0] shreg;
    logic [7:0] data_aligned;
    logic [3:0] bit_idx;
    logic       stop_idx;
    logic       err_bit;
    logic       shift_en;
    logic       par_chk_en;
    logic       stop_cnt_en;
    logic       flag_next;
    logic       ferr_next;

    // Two-flop synchronizer plus one delay stage for edge detection
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            rx_s1 <= 1'b1;
            rx_s2 <= 1'b1;
            rx_d  <= 1'b1;
        end else begin
            rx_s1 <= rx;
            rx_s2 <= rx_s1;
            rx_d  <= rx_s2;
        end
    end

    assign fall = rx_d & ~rx_s2;

`ifdef UART_RX_MAJORITY_EN
    logic rx_dd;

    // Extra delay stage so three consecutive samples are visible at once
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            rx_dd <= 1'b1;
        end else begin
            rx_dd <= rx_d;
        end
    end

    assign bit_val = maj3(rx_dd, rx_d, rx_s2);
`else
    assign bit_val = rx_d;
`endif

    assign restart      = (state_next != state);
    assign data_aligned = shreg >> (8 - DATA_BITS);

    uart_baud_gen #(
        .BAUD_CNT_MAX(BAUD_CNT_MAX)
    ) u_baud (
        .clk    (sys_clk),
        .rst_n  (sys_rst_n),
        .restart(restart),
        .smp_stb(smp_stb),
        .bit_end(bit_end)
    );

    // FSM state register
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next-state logic; STOP leaves at its sample point so IDLE is
    // re-entered half a bit early and back-to-back frames are caught
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (fall) state_next = ST_START;
                else      state_next = ST_IDLE;
            end
            ST_START: begin
                if (smp_stb && bit_val) state_next = ST_IDLE;
                else if (bit_end)       state_next = ST_DATA;
                else                    state_next = ST_START;
            end
            ST_DATA: begin
                if (bit_end && (bit_idx == DATA_CNT)) begin
                    if (PARITY != PAR_NONE) state_next = ST_PARITY;
                    else                    state_next = ST_STOP;
                end else begin
                    state_next = ST_DATA;
                end
            end
            ST_PARITY: begin
                if (bit_end) state_next = ST_STOP;
                else         state_next = ST_PARITY;
            end
            ST_STOP: begin
                if (smp_stb && !bit_val)                        state_next = ST_RECOVER;
                else if (smp_stb && (stop_idx == LAST_STOP))    state_next = ST_IDLE;
                else                                            state_next = ST_STOP;
            end
            ST_RECOVER: begin
                if (rx_s2) state_next = ST_IDLE;
                else       state_next = ST_RECOVER;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // FSM output decode: datapath enables and next-cycle pulses
    always_comb begin
        shift_en    = 1'b0;
        par_chk_en  = 1'b0;
        stop_cnt_en = 1'b0;
        flag_next   = 1'b0;
        ferr_next   = 1'b0;
        case (state)
            ST_DATA:   shift_en   = smp_stb;
            ST_PARITY: par_chk_en = smp_stb;
            ST_STOP: begin
                stop_cnt_en = smp_stb;
                flag_next   = smp_stb & bit_val & (stop_idx == LAST_STOP);
                ferr_next   = smp_stb & ~bit_val;
            end
            default: begin
                shift_en = 1'b0;
            end
        endcase
    end

    // Frame datapath: LSB-first shift register, bit/stop counters, parity error
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            shreg    <= 8'h00;
            bit_idx  <= 4'd0;
            stop_idx <= 1'b0;
            err_bit  <= 1'b0;
        end else begin
            if (shift_en) begin
                shreg <= {bit_val, shreg[7:1]};
            end
            if (state != ST_DATA) begin
                bit_idx <= 4'd0;
            end else if (shift_en) begin
                bit_idx <= bit_idx + 4'd1;
            end
            if (state != ST_STOP) begin
                stop_idx <= 1'b0;
            end else if (stop_cnt_en) begin
                stop_idx <= ~stop_idx;
            end
            if (state == ST_IDLE) begin
                err_bit <= 1'b0;
            end else if (par_chk_en) begin
                err_bit <= bit_val ^ parity_bit(data_aligned, PARITY);
            end
        end
    end

    // Registered outputs; po_data only moves on a good frame
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            po_data    <= 8'h00;
            po_flag    <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            po_flag    <= flag_next;
            frame_err  <= ferr_next;
            parity_err <= flag_next & err_bit;
            if (flag_next) begin
                po_data <= data_aligned;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_multi.sv
// tb_uart_rx_multi: self-checking bench for uart_rx_multi.
// Instance a: 8N1; instance b: 8E1. 100 clocks per bit keeps the run short.
module tb_uart_rx_multi;

    import uart_pkg::*;

    localparam int CLK_FREQ = 25_000_000;
    localparam int BAUD     = 250_000;
    localparam int BIT      = CLK_FREQ / BAUD;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx_a  = 1'b1;
    logic       rx_b  = 1'b1;
    logic [7:0] data_a, data_b;
    logic       flag_a, flag_b, perr_a, perr_b, ferr_a, ferr_b;

    always #20 clk = ~clk;

    uart_rx_multi #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD)) u_a (
        .sys_clk(clk), .sys_rst_n(rst_n), .rx(rx_a),
        .po_data(data_a), .po_flag(flag_a), .parity_err(perr_a), .frame_err(ferr_a)
    );

    uart_rx_multi #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD), .PARITY(PAR_EVEN)) u_b (
        .sys_clk(clk), .sys_rst_n(rst_n), .rx(rx_b),
        .po_data(data_b), .po_flag(flag_b), .parity_err(perr_b), .frame_err(ferr_b)
    );

    typedef struct packed {
        logic [7:0] data;
        logic       perr;
    } exp_t;

    typedef struct {
        logic [7:0] data;
        logic       stop_v;
        logic       exp_flag;
        logic [7:0] exp_data;
    } vec_t;

    exp_t q_a[$];
    exp_t q_b[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   flag_cnt_a = 0;
    int   flag_cnt_b = 0;
    int   ferr_cnt_a = 0;
    int   last_flag_cyc_a = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name, input int act, input int exp);
        checks++;
        errors++;
        $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Cycle counter for latency measurement
    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard monitor: pop expected frames as the DUTs report them
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (flag_a) begin
                flag_cnt_a++;
                last_flag_cyc_a = cyc;
                if (q_a.size() == 0) begin
                    fail_now("a_unexpected_flag", flag_cnt_a, 0);
                end else begin
                    e = q_a.pop_front();
                    check("a_data", {24'h0, data_a}, {24'h0, e.data});
                    check("a_parity_err", {31'h0, perr_a}, {31'h0, e.perr});
                end
            end
            if (ferr_a) ferr_cnt_a++;
            if (flag_a || ferr_a) check("a_flag_ferr_exclusive", {31'h0, flag_a & ferr_a}, 32'h0);
            if (flag_b) begin
                flag_cnt_b++;
                if (q_b.size() == 0) begin
                    fail_now("b_unexpected_flag", flag_cnt_b, 0);
                end else begin
                    e = q_b.pop_front();
                    check("b_data", {24'h0, data_b}, {24'h0, e.data});
                    check("b_parity_err", {31'h0, perr_b}, {31'h0, e.perr});
                end
            end
            if (ferr_b) fail_now("b_unexpected_frame_err", 1, 0);
        end
    end

    // Drive one frame; par < 0 means no parity bit; glitch inverts one cycle
    task automatic send(input bit sel, input logic [7:0] data, input int par,
                        input logic stop_v, input int glitch);
        logic bits[$];
        logic v;
        bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) bits.push_back(data[i]);
        if (par >= 0) bits.push_back(par[0]);
        bits.push_back(stop_v);
        for (int c = 0; c < bits.size() * BIT; c++) begin
            v = bits[c / BIT];
            if (c == glitch) v = ~v;
            if (sel) rx_b = v;
            else     rx_a = v;
            @(negedge clk);
        end
    endtask

    task automatic idle_bits(input int n);
        rx_a = 1'b1;
        rx_b = 1'b1;
        repeat (n * BIT) @(negedge clk);
    endtask

    vec_t tbl[8];
    int   start_cyc;
    int   lat;

    initial begin
        for (int i = 0; i < 8; i++) begin
            tbl[i] = '{data: 8'(i), stop_v: 1'b1, exp_flag: 1'b1, exp_data: 8'(i)};
        end

        // Reset state
        repeat (5) @(negedge clk);
        check("rst_data_a", {24'h0, data_a}, 32'h0);
        check("rst_flag_a", {31'h0, flag_a}, 32'h0);
        check("rst_perr_a", {31'h0, perr_a}, 32'h0);
        check("rst_ferr_a", {31'h0, ferr_a}, 32'h0);
        check("rst_data_b", {24'h0, data_b}, 32'h0);
        rst_n = 1'b1;
        idle_bits(2);

        // Single 0x55 frame with latency window
        q_a.push_back('{data: 8'h55, perr: 1'b0});
        start_cyc = cyc;
        send(1'b0, 8'h55, -1, 1'b1, -1);
        check("x55_flag_count", flag_cnt_a, 1);
        lat = last_flag_cyc_a - start_cyc;
        checks++;
        if (lat < BIT * 19 / 2 || lat > BIT * 19 / 2 + 10) begin
            errors++;
            $display("FAIL x55_latency: got %0d cycles expected %0d..%0d", lat, BIT * 19 / 2, BIT * 19 / 2 + 10);
        end
        idle_bits(1);

        // Back-to-back table frames, zero idle
        for (int i = 0; i < 8; i++) begin
            if (tbl[i].exp_flag) q_a.push_back('{data: tbl[i].exp_data, perr: 1'b0});
            send(1'b0, tbl[i].data, -1, tbl[i].stop_v, -1);
        end
        idle_bits(2);
        check("b2b_flag_count", flag_cnt_a, 9);
        check("b2b_last_data", {24'h0, data_a}, 32'h07);

        // False start: short low pulse
        rx_a = 1'b0;
        repeat (10) @(negedge clk);
        rx_a = 1'b1;
        idle_bits(2);
        check("false_start_flags", flag_cnt_a, 9);
        check("false_start_ferr", ferr_cnt_a, 0);
        check("false_start_state", {29'h0, u_a.state}, {29'h0, ST_IDLE});

        // Bad stop bit, then break, then a good frame
        send(1'b0, 8'h3C, -1, 1'b0, -1);
        rx_a = 1'b0;
        repeat (20 * BIT) @(negedge clk);
        check("break_ferr_count", ferr_cnt_a, 1);
        check("break_no_flag", flag_cnt_a, 9);
        check("break_data_held", {24'h0, data_a}, 32'h07);
        check("break_state", {29'h0, u_a.state}, {29'h0, ST_RECOVER});
        idle_bits(1);
        q_a.push_back('{data: 8'hA3, perr: 1'b0});
        send(1'b0, 8'hA3, -1, 1'b1, -1);
        idle_bits(1);
        check("after_break_data", {24'h0, data_a}, 32'hA3);
        check("after_break_ferr", ferr_cnt_a, 1);

        // Even parity: wrong bit then correct bit
        q_b.push_back('{data: 8'h07, perr: 1'b1});
        send(1'b1, 8'h07, 0, 1'b1, -1);
        q_b.push_back('{data: 8'h07, perr: 1'b0});
        send(1'b1, 8'h07, 1, 1'b1, -1);
        idle_bits(1);
        check("parity_flag_count", flag_cnt_b, 2);

        // Reset in the middle of a byte
        rx_a = 1'b0;
        repeat (3 * BIT) @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("midrst_data", {24'h0, data_a}, 32'h0);
        check("midrst_flag", {31'h0, flag_a}, 32'h0);
        check("midrst_ferr", {31'h0, ferr_a}, 32'h0);
        check("midrst_state", {29'h0, u_a.state}, {29'h0, ST_IDLE});
        rx_a = 1'b1;
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        idle_bits(12);
        check("midrst_no_pulse", flag_cnt_a, 10);
        check("midrst_no_ferr", ferr_cnt_a, 1);
        q_a.push_back('{data: 8'h81, perr: 1'b0});
        send(1'b0, 8'h81, -1, 1'b1, -1);
        idle_bits(1);
        check("midrst_new_data", {24'h0, data_a}, 32'h81);

`ifdef UART_RX_MAJORITY_EN
        // One-clock glitch on data bit 0 at the sample point
        q_a.push_back('{data: 8'h0F, perr: 1'b0});
        send(1'b0, 8'h0F, -1, 1'b1, BIT + BIT / 2 + 1);
        idle_bits(1);
        check("glitch_data", {24'h0, data_a}, 32'h0F);
`endif

        check("queue_a_empty", q_a.size(), 0);
        check("queue_b_empty", q_b.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
